// File: rtl/matrix_add_pipe.sv
// matrix_add_pipe: two-stage lane-parallel adder rebuilding matrix rows from
// difference and base beats, with row tracking and a sticky overflow flag.
module matrix_add_pipe #(
    parameter int PARALLEL_NUM = 28,
    parameter int ROWS         = 28,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*PARALLEL_NUM-1:0] diffSet,
    input  logic [16*PARALLEL_NUM-1:0] baseSet,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [16*PARALLEL_NUM-1:0] sumSet,
    output logic [$clog2(ROWS)-1:0]   out_row,
    output logic                      out_last,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int PN = PARALLEL_NUM;
    localparam int W  = 16 * PN;
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic                s1_valid;
    logic [PN-1:0][16:0] s1_sum;
    logic [PN-1:0]       s1_ovf;
    logic [PN-1:0][16:0] sum_nxt;
    logic [PN-1:0]       ovf_nxt;

    logic                s2_valid;
    logic [W-1:0]        s2_res;
    logic                s2_ovf;
    logic [W-1:0]        res_nxt;

    logic [RW-1:0]       row;
    logic                s1_en;
    logic                s2_en;
    logic                out_xfer;

    assign s2_en    = !s2_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign out_xfer = s2_valid && out_ready;

    assign out_valid = s2_valid;
    assign sumSet    = s2_res;
    assign out_row   = row;
    assign out_last  = s2_valid && (row == LAST_ROW);

    // Sign-extend each lane to 17 bits and flag lanes whose sum leaves 16 bits.
    always_comb begin
        sum_nxt = '0;
        ovf_nxt = '0;
        for (int i = 0; i < PN; i++) begin
            sum_nxt[i] = {diffSet[i*16+15], diffSet[i*16 +: 16]}
                       + {baseSet[i*16+15], baseSet[i*16 +: 16]};
            ovf_nxt[i] = sum_nxt[i][16] ^ sum_nxt[i][15];
        end
    end

    // Reduce each 17-bit lane sum to 16 bits by wrapping or clamping.
    always_comb begin
        res_nxt = '0;
        for (int i = 0; i < PN; i++) begin
            if (SATURATE && s1_ovf[i]) begin
                res_nxt[i*16 +: 16] = s1_sum[i][16] ? 16'h8000 : 16'h7fff;
            end else begin
                res_nxt[i*16 +: 16] = s1_sum[i][15:0];
            end
        end
    end

    // Stage 1: capture the raw lane sums whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ovf   <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum <= sum_nxt;
                s1_ovf <= ovf_nxt;
            end
        end
    end

    // Stage 2: hold the finished beat until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_ovf   <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= res_nxt;
                s2_ovf <= |s1_ovf;
            end
        end
    end

    // Row position within the frame advances with each delivered beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (out_xfer) begin
            row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end
    end

    // Sticky overflow; a new overflow outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (out_xfer && s2_ovf) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: doc/matrix_add_pipe.md
MATRIX_ADD_PIPE -- requirements
Module: matrix_add_pipe

Interface
REQ-001 SHALL have parameter PARALLEL_NUM, default 28, number of 16-bit signed lanes per beat.
REQ-002 SHALL have parameter ROWS, default 28, number of beats per matrix frame.
REQ-003 SHALL have parameter SATURATE, default 0; 0 = wrap (modulo 2^16), 1 = clamp to [-32768, 32767].
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  the input beat is valid.
REQ-007 SHALL have port in_ready  output  1  the block accepts an input beat this cycle.
REQ-008 SHALL have port diffSet  input  16*PARALLEL_NUM  difference lanes; lane i is bits [i*16 +: 16], signed.
REQ-009 SHALL have port baseSet  input  16*PARALLEL_NUM  base lanes, same packing, signed.
REQ-010 SHALL have port out_valid  output  1  the output beat is valid.
REQ-011 SHALL have port out_ready  input  1  the downstream side accepts the output beat.
REQ-012 SHALL have port sumSet  output  16*PARALLEL_NUM  reconstructed lanes, diff[i] + base[i], same packing.
REQ-013 SHALL have port out_row  output  $clog2(ROWS)  row index of the current output beat within its frame.
REQ-014 SHALL have port out_last  output  1  high with out_valid when out_row == ROWS-1.
REQ-015 SHALL have port ovf  output  1  sticky flag: a transferred beat overflowed in at least one lane.
REQ-016 SHALL have port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-018 SHALL be a 2-stage pipeline. S1 registers 17-bit sign-extended sums per lane plus a per-lane overflow bit; S2 registers the wrapped or clamped 16-bit results and one beat overflow bit (OR over lanes).
REQ-019 S2 SHALL load when S2 is empty or the output transfers. S1 SHALL load when S1 is empty or S1 moves into S2. in_ready = !s1_valid || (!s2_valid || out_ready), driven combinationally.
REQ-020 Latency SHALL be 2 cycles: a beat accepted at edge N is on sumSet with out_valid high after edge N+1 if out_ready stays high. Throughput SHALL be 1 beat per cycle.
REQ-021 sumSet, out_row and out_last SHALL stay stable while out_valid && !out_ready. No beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-022 Lane overflow SHALL mean sum bit 16 != sum bit 15.
REQ-023 With SATURATE=0, the lane result SHALL be sum[15:0]. With SATURATE=1, positive overflow SHALL give 16'h7FFF and negative overflow SHALL give 16'h8000.
REQ-024 The row counter SHALL increment on each output transfer and wrap from ROWS-1 to 0. out_row SHALL equal the counter value.
REQ-025 ovf SHALL set on an output transfer of a beat with its overflow bit set. It SHALL clear when ovf_clr=1. If both happen in the same cycle, set wins.
REQ-026 in_valid, diffSet and baseSet SHALL be ignored when in_ready=0.

Reset
REQ-027 While rst_n=0, asynchronously: s1_valid=0, s2_valid=0, out_valid=0, sumSet=0, out_row=0, out_last=0, ovf=0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-029 Reset asserted mid-frame SHALL discard in-flight beats and restart the row count at 0.

Verification
REQ-030 Lane 0: diff=5, base=-3, out_ready=1 -> sumSet lane 0 = 2 and out_valid high 2 cycles after acceptance; all other lanes = diff+base.
REQ-031 Lane 3: diff=0x7FFF, base=1. SATURATE=0 -> 0x8000 and ovf=1. SATURATE=1 -> 0x7FFF and ovf=1. Then ovf_clr pulse -> ovf=0.
REQ-032 Stream 28 beats with out_ready held 0 for cycles 3-7: in_ready falls once S1 and S2 are full. After release, all 28 results arrive in order, out_last only on beat 27, out_row returns to 0.
REQ-033 Random in_valid and out_ready for 10k beats, checked against a scoreboard: exact order and values, no loss, no duplicates, stable outputs during stall.
REQ-034 Assert rst_n=0 with 2 beats in flight at out_row=9 -> out_valid=0 immediately. After release, the next beat has out_row=0 and ovf=0.
REQ-035 ovf_clr=1 in the same cycle as transfer of an overflowing beat -> ovf=1 the next cycle.
